// File: rtl/sha3_feed_ctrl_if.sv
// sha3_feed_ctrl_if: burst request handshake and beat bus between the feed controller and its bus master.
interface sha3_feed_ctrl_if #(parameter int BUS_W = 128) ();
   logic             init_master_txn;
   logic [31:0]      read_addr_index;
   logic             read_active;
   logic             read_done;
   logic [BUS_W-1:0] bus_data;
   logic             bus_data_valid;
   logic             read_ready;
   modport master (output init_master_txn, read_addr_index, read_ready,
                   input  read_active, read_done, bus_data, bus_data_valid);
   modport slave  (input  init_master_txn, read_addr_index, read_ready,
                   output read_active, read_done, bus_data, bus_data_valid);
endinterface

// File: rtl/sha3_feed_ctrl.sv
// sha3_feed_ctrl: fetches bursts into a word FIFO and drains them to the keccak sink or the capture register.
module sha3_feed_ctrl #(
   parameter int BUS_W      = 128,
   parameter int WORD_W     = 64,
   parameter int NUM_WORDS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int BEATS      = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   sha3_feed_ctrl_if.master            bus,
   input  logic                        start,
   input  logic [7:0]                  num_bursts,
   input  logic                        mode,
   output logic [WORD_W-1:0]           keccak_input,
   output logic                        in_ready,
   output logic                        is_last,
   input  logic                        buffer_full,
   output logic [NUM_WORDS*WORD_W-1:0] result,
   output logic                        busy,
   output logic                        done,
   output logic                        overflow
);
   localparam int R  = BUS_W / WORD_W;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (8 + $clog2(BEATS*R+1) > 16) ? 8 + $clog2(BEATS*R+1) : 16;
   localparam int SW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;

   if (BUS_W % WORD_W != 0 || FIFO_DEPTH < 2*R || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_bad_params
      $error("sha3_feed_ctrl: illegal BUS_W/WORD_W/FIFO_DEPTH combination");
   end

   typedef enum logic [2:0] {IDLE, REQ, WAIT_ACT, WAIT_DONE, FIN} state_t;
   state_t                      state_q, state_d;
   logic [WORD_W-1:0]           mem_q [FIFO_DEPTH];
   logic [AW-1:0]               wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]                 cnt_q, cnt_d, free;
   logic [31:0]                 idx_q, idx_d;
   logic [7:0]                  nb_q, nb_d;
   logic                        mode_q, mode_d, ovf_q, ovf_d;
   logic [CW-1:0]               exp_q, exp_d, drn_q, drn_d;
   logic [SW-1:0]               slot_q, slot_d;
   logic [NUM_WORDS*WORD_W-1:0] res_q, res_d;
   logic                        go, push, pop;

   assign free                = (AW+1)'(FIFO_DEPTH) - cnt_q;
   assign go                  = state_q == IDLE && start;
   assign push                = bus.bus_data_valid && free >= (AW+1)'(R);
   // Draining never runs past the expected count; stream mode additionally honours sink backpressure.
   assign pop                 = state_q != IDLE && cnt_q != '0 && drn_q != exp_q && !(mode_q && buffer_full);
   assign done                = state_q == FIN && drn_q == exp_q;
   assign busy                = state_q != IDLE;
   assign overflow            = ovf_q;
   assign result              = res_q;
   assign keccak_input        = mem_q[rd_q];
   assign in_ready            = pop && mode_q;
   assign is_last             = in_ready && (drn_q + CW'(1)) == exp_q;
   assign bus.read_ready      = free >= (AW+1)'(FIFO_DEPTH/2);
   assign bus.init_master_txn = state_q == REQ && bus.read_ready;
   assign bus.read_addr_index = idx_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      nb_d    = nb_q;
      mode_d  = mode_q;
      exp_d   = exp_q;
      res_d   = res_q;
      cnt_d   = done ? '0 : cnt_q + (push ? (AW+1)'(R) : '0) - (AW+1)'(pop);
      wr_d    = done ? '0 : wr_q + (push ? AW'(R) : '0);
      rd_d    = done ? '0 : rd_q + AW'(pop);
      drn_d   = go ? '0 : drn_q + CW'(pop);
      slot_d  = go ? '0 : !pop ? slot_q : slot_q == SW'(NUM_WORDS-1) ? '0 : slot_q + SW'(1);
      ovf_d   = (go ? 1'b0 : ovf_q) | (bus.bus_data_valid && !push);
      if (pop && !mode_q) res_d[WORD_W*slot_q +: WORD_W] = mem_q[rd_q];
      case (state_q)
         IDLE: if (start) begin
            idx_d   = '0;
            nb_d    = num_bursts;
            mode_d  = mode;
            exp_d   = CW'(num_bursts) * CW'(BEATS*R);
            state_d = num_bursts != '0 ? REQ : FIN;
         end
         REQ:       state_d = bus.read_ready ? WAIT_ACT : REQ;
         WAIT_ACT:  state_d = bus.read_active ? WAIT_DONE : WAIT_ACT;
         WAIT_DONE: if (bus.read_done) begin
            idx_d   = idx_q + 32'd1;
            state_d = idx_d < {24'd0, nb_q} ? REQ : FIN;
         end
         FIN:       state_d = done ? IDLE : FIN;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         nb_q    <= '0;
         mode_q  <= 1'b0;
         ovf_q   <= 1'b0;
         exp_q   <= '0;
         drn_q   <= '0;
         slot_q  <= '0;
         res_q   <= {(NUM_WORDS*WORD_W/8){8'hC3}};
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         nb_q    <= nb_d;
         mode_q  <= mode_d;
         ovf_q   <= ovf_d;
         exp_q   <= exp_d;
         drn_q   <= drn_d;
         slot_q  <= slot_d;
         res_q   <= res_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) for (int i = 0; i < R; i++) mem_q[wr_q + AW'(i)] <= bus.bus_data[WORD_W*i +: WORD_W];
   end
endmodule

// File: tb/tb_sha3_feed_ctrl.sv
// tb_sha3_feed_ctrl: randomized jobs against a queue-based model of the feed controller.
module tb_sha3_feed_ctrl;
   logic         clk = 1'b0;
   logic         reset, start, mode, buffer_full;
   logic [7:0]   num_bursts;
   logic [63:0]  keccak_input;
   logic         in_ready, is_last, busy, done, overflow;
   logic [511:0] result;
   int           n_checks = 0, n_fail = 0;

   sha3_feed_ctrl_if #(.BUS_W(128)) bus ();

   sha3_feed_ctrl dut (
      .clk(clk), .reset(reset), .bus(bus), .start(start), .num_bursts(num_bursts), .mode(mode),
      .keccak_input(keccak_input), .in_ready(in_ready), .is_last(is_last), .buffer_full(buffer_full),
      .result(result), .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   logic [63:0] model_res [8];
   logic [63:0] sent [$];
   logic [63:0] got [$];
   logic [31:0] idx_seen [$];
   int          last_pos [$];
   int          n_init, n_done, done_cyc, bf_viol, tmo;
   logic        busy_after;

   task automatic idle_inputs();
      start = 0; num_bursts = 0; mode = 0; buffer_full = 0;
      bus.read_active = 0; bus.read_done = 0; bus.bus_data_valid = 0; bus.bus_data = '0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) model_res[i] = {8{8'hC3}};
   endtask

   // Acts as a one-beat-per-burst bus slave and records everything the DUT emits until done.
   task automatic run_job(input bit m, input int nb, input int bf_mode, input bit seq_data, input bit restart);
      int sl = 0, cyc = 0, k = 0;
      logic [63:0] w0, w1;
      n_init = 0; n_done = 0; done_cyc = -1; bf_viol = 0;
      sent.delete(); got.delete(); idx_seen.delete(); last_pos.delete();
      while (n_done == 0 && cyc < 1000) begin
         @(negedge clk);
         start = (cyc == 0) || (restart && cyc == 3);
         num_bursts = (cyc == 0) ? 8'(nb) : 8'(nb + 1);
         mode = (cyc == 0) ? m : !m;
         buffer_full = bf_mode == 0 ? 1'b0 : bf_mode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
         bus.read_active = sl == 1;
         bus.read_done = sl == 3;
         bus.bus_data_valid = sl == 2;
         if (sl == 2) begin
            w0 = seq_data ? 64'(2*k) : {$urandom, $urandom};
            w1 = seq_data ? 64'(2*k+1) : {$urandom, $urandom};
            bus.bus_data = {w1, w0};
            sent.push_back(w0); sent.push_back(w1);
            k++;
         end
         #1;
         if (bus.init_master_txn) begin n_init++; idx_seen.push_back(bus.read_addr_index); end
         if (in_ready) begin got.push_back(keccak_input); if (buffer_full) bf_viol++; end
         if (is_last) last_pos.push_back(got.size());
         if (done) begin n_done++; done_cyc = cyc; end
         sl = sl == 0 ? (bus.init_master_txn ? 1 : 0) : sl == 3 ? 0 : sl + 1;
         cyc++;
      end
      tmo = n_done == 0 ? 1 : 0;
      @(negedge clk);
      idle_inputs();
      #1;
      busy_after = busy;
      if (done) n_done++;
      if (!m) for (int i = 0; i < sent.size(); i++) model_res[i % 8] = sent[i];
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1; start = 1; num_bursts = 8'd3; bus.bus_data_valid = 1;
      repeat (2) @(negedge clk);
      reset = 0; idle_inputs();
      model_reset();
      #1;
      n_checks++; if ({busy, done, overflow, in_ready, is_last, bus.init_master_txn} !== 6'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 000000", {busy, done, overflow, in_ready, is_last, bus.init_master_txn});
      end
      n_checks++; if (bus.read_addr_index !== 32'd0) begin n_fail++; $display("FAIL reset_index: got %0d want 0", bus.read_addr_index); end
      n_checks++; if (bus.read_ready !== 1'b1) begin n_fail++; $display("FAIL reset_read_ready: got %b want 1", bus.read_ready); end
      n_checks++; if (result !== {64{8'hC3}}) begin n_fail++; $display("FAIL reset_result: got %h want all C3", result); end
   endtask

   task automatic test_capture();
      run_job(0, 4, 0, 1, 0);
      n_checks++; if (tmo != 0) begin n_fail++; $display("FAIL capture_timeout: no done within budget"); end
      n_checks++; if (n_init != 4) begin n_fail++; $display("FAIL capture_inits: got %0d want 4", n_init); end
      for (int i = 0; i < idx_seen.size(); i++) begin
         n_checks++; if (idx_seen[i] !== 32'(i)) begin n_fail++; $display("FAIL capture_index[%0d]: got %0d want %0d", i, idx_seen[i], i); end
      end
      n_checks++; if (got.size() != 0 || last_pos.size() != 0) begin n_fail++; $display("FAIL capture_in_ready: got %0d words %0d lasts want 0", got.size(), last_pos.size()); end
      for (int i = 0; i < 8; i++) begin
         n_checks++; if (result[64*i +: 64] !== 64'(i)) begin n_fail++; $display("FAIL capture_word[%0d]: got %h want %h", i, result[64*i +: 64], i); end
      end
      n_checks++; if (n_done != 1 || busy_after !== 1'b0) begin n_fail++; $display("FAIL capture_done: got %0d pulses busy %b want 1 pulse busy 0", n_done, busy_after); end
   endtask

   task automatic test_stream();
      run_job(1, 2, 1, 0, 0);
      n_checks++; if (tmo != 0 || got.size() != 4) begin n_fail++; $display("FAIL stream_count: got %0d words want 4", got.size()); end
      for (int i = 0; i < got.size() && i < sent.size(); i++) begin
         n_checks++; if (got[i] !== sent[i]) begin n_fail++; $display("FAIL stream_word[%0d]: got %h want %h", i, got[i], sent[i]); end
      end
      n_checks++; if (bf_viol != 0) begin n_fail++; $display("FAIL stream_backpressure: got %0d words while full want 0", bf_viol); end
      n_checks++; if (last_pos.size() != 1 || last_pos[0] != 4) begin n_fail++; $display("FAIL stream_is_last: got %0d marks (first %0d) want one at word 4", last_pos.size(), last_pos.size() ? last_pos[0] : -1); end
      n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL stream_done: got %0d pulses want 1", n_done); end
      for (int i = 0; i < 8; i++) begin
         n_checks++; if (result[64*i +: 64] !== model_res[i]) begin n_fail++; $display("FAIL stream_result_hold[%0d]: got %h want %h", i, result[64*i +: 64], model_res[i]); end
      end
   endtask

   task automatic test_zero_bursts();
      run_job(0, 0, 0, 1, 0);
      n_checks++; if (n_init != 0) begin n_fail++; $display("FAIL zero_inits: got %0d want 0", n_init); end
      n_checks++; if (done_cyc != 1 || n_done != 1) begin n_fail++; $display("FAIL zero_done: got cycle %0d pulses %0d want cycle 1 pulses 1", done_cyc, n_done); end
      n_checks++; if (result !== {model_res[7], model_res[6], model_res[5], model_res[4], model_res[3], model_res[2], model_res[1], model_res[0]}) begin
         n_fail++; $display("FAIL zero_result: got %h changed", result);
      end
   endtask

   task automatic test_overflow();
      logic [63:0] q [$];
      logic [63:0] w0, w1;
      @(negedge clk); start = 1; num_bursts = 8'd1; mode = 1; buffer_full = 1;
      @(negedge clk); start = 0; #1;
      n_checks++; if (bus.init_master_txn !== 1'b1) begin n_fail++; $display("FAIL ovf_init: got %b want 1", bus.init_master_txn); end
      @(negedge clk); bus.read_active = 1;
      for (int b = 0; b < 8; b++) begin
         @(negedge clk); bus.read_active = 0; bus.bus_data_valid = 1;
         w0 = {$urandom, $urandom}; w1 = {$urandom, $urandom};
         bus.bus_data = {w1, w0}; q.push_back(w0); q.push_back(w1);
      end
      @(negedge clk); bus.bus_data_valid = 0; buffer_full = 0; #1;
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_premature: got %b want 0", overflow); end
      n_checks++; if (in_ready !== 1'b1 || keccak_input !== q[0]) begin n_fail++; $display("FAIL ovf_head: got %b %h want 1 %h", in_ready, keccak_input, q[0]); end
      @(negedge clk); buffer_full = 1; bus.bus_data_valid = 1; bus.bus_data = {$urandom, $urandom, $urandom, $urandom}; #1;
      n_checks++; if (bus.read_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_read_ready: got %b want 0", bus.read_ready); end
      @(negedge clk); bus.bus_data = {$urandom, $urandom, $urandom, $urandom}; #1;
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
      @(negedge clk); bus.bus_data_valid = 0; bus.read_done = 1;
      @(negedge clk); bus.read_done = 0; buffer_full = 0; #1;
      n_checks++; if ({in_ready, is_last, done} !== 3'b110 || keccak_input !== q[1]) begin
         n_fail++; $display("FAIL ovf_last_word: got %b %h want 110 %h", {in_ready, is_last, done}, keccak_input, q[1]);
      end
      @(negedge clk); #1;
      n_checks++; if (done !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_done: got done %b in_ready %b want 1 0", done, in_ready); end
      @(negedge clk); #1;
      n_checks++; if ({busy, overflow, bus.read_ready} !== 3'b011) begin n_fail++; $display("FAIL ovf_after_job: got %b want 011", {busy, overflow, bus.read_ready}); end
      run_job(0, 1, 0, 1, 0);
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_on_start: got %b want 0", overflow); end
      n_checks++; if (result[127:0] !== {model_res[1], model_res[0]}) begin n_fail++; $display("FAIL ovf_flushed: got %h want %h", result[127:0], {model_res[1], model_res[0]}); end
   endtask

   task automatic test_wrap();
      run_job(0, 6, 2, 1, 0);
      n_checks++; if (tmo != 0 || n_init != 6) begin n_fail++; $display("FAIL wrap_inits: got %0d want 6", n_init); end
      for (int i = 0; i < 8; i++) begin
         n_checks++; if (result[64*i +: 64] !== 64'(i < 4 ? i + 8 : i)) begin
            n_fail++; $display("FAIL wrap_word[%0d]: got %h want %h", i, result[64*i +: 64], i < 4 ? i + 8 : i);
         end
      end
   endtask

   task automatic test_reset_mid_job();
      int extra_done = 0;
      @(negedge clk); start = 1; num_bursts = 8'd3; mode = 0;
      @(negedge clk); start = 0;
      @(negedge clk); bus.read_active = 1;
      @(negedge clk); bus.read_active = 0; #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy); end
      @(negedge clk); reset = 1; start = 1; bus.read_done = 1; bus.bus_data_valid = 1;
      @(negedge clk); reset = 0; idle_inputs(); model_reset(); #1;
      n_checks++; if ({busy, done, overflow, in_ready, is_last, bus.init_master_txn} !== 6'b0 || bus.read_addr_index !== 32'd0) begin
         n_fail++; $display("FAIL mid_reset_outputs: got %b idx %0d want 000000 idx 0", {busy, done, overflow, in_ready, is_last, bus.init_master_txn}, bus.read_addr_index);
      end
      n_checks++; if (result !== {64{8'hC3}}) begin n_fail++; $display("FAIL mid_reset_result: got %h want all C3", result); end
      repeat (5) begin @(negedge clk); #1; if (done) extra_done++; end
      n_checks++; if (extra_done != 0) begin n_fail++; $display("FAIL mid_no_done: got %0d pulses want 0", extra_done); end
      run_job(1, 3, 2, 0, 1);
      n_checks++; if (n_init != 3 || n_done != 1 || got.size() != 6) begin
         n_fail++; $display("FAIL mid_rerun: got inits %0d dones %0d words %0d want 3 1 6", n_init, n_done, got.size());
      end
   endtask

   task automatic test_random_jobs();
      bit m;
      int nb;
      for (int j = 0; j < 6; j++) begin
         m = 1'($urandom_range(0, 1));
         nb = $urandom_range(1, 5);
         run_job(m, nb, 2, 0, 1);
         n_checks++; if (tmo != 0 || n_init != nb || n_done != 1) begin
            n_fail++; $display("FAIL rand%0d_job: got inits %0d dones %0d want %0d 1", j, n_init, n_done, nb);
         end
         for (int i = 0; i < idx_seen.size(); i++) begin
            n_checks++; if (idx_seen[i] !== 32'(i)) begin n_fail++; $display("FAIL rand%0d_index[%0d]: got %0d want %0d", j, i, idx_seen[i], i); end
         end
         if (m) begin
            n_checks++; if (got != sent || bf_viol != 0) begin n_fail++; $display("FAIL rand%0d_stream: got %0d words %0d violations want %0d words 0", j, got.size(), bf_viol, sent.size()); end
            n_checks++; if (last_pos.size() != 1 || last_pos[0] != 2*nb) begin n_fail++; $display("FAIL rand%0d_is_last: got %0d marks want one at %0d", j, last_pos.size(), 2*nb); end
         end else begin
            for (int i = 0; i < 8; i++) begin
               n_checks++; if (result[64*i +: 64] !== model_res[i]) begin n_fail++; $display("FAIL rand%0d_result[%0d]: got %h want %h", j, i, result[64*i +: 64], model_res[i]); end
            end
         end
      end
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      test_reset();
      test_capture();
      test_stream();
      test_zero_bursts();
      test_overflow();
      test_wrap();
      test_reset_mid_job();
      test_random_jobs();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sha3_feed_ctrl.md
SHA3_FEED_CTRL -- requirements
Module: sha3_feed_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): BUS_W, 128, bus beat width; WORD_W, 64, word width; NUM_WORDS, 8, result slots; FIFO_DEPTH, 16, FIFO words; BEATS, 1, beats per burst.
REQ-002 SHALL reject elaboration unless BUS_W is a multiple of WORD_W and FIFO_DEPTH is a power of 2 with FIFO_DEPTH >= 2*R, where R = BUS_W/WORD_W.
REQ-003 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle job start; num_bursts  in  8  bursts per job, sampled at start; mode  in  1  0=capture, 1=stream, sampled at start.
REQ-005 init_master_txn  out  1  burst request pulse; read_addr_index  out  32  current burst index; read_active  in  1  master accepted request; read_done  in  1  burst complete.
REQ-006 bus_data  in  BUS_W  beat data; bus_data_valid  in  1  beat strobe; read_ready  out  1  FIFO can accept a burst.
REQ-007 keccak_input  out  WORD_W  stream word; in_ready  out  1  word valid; is_last  out  1  final word of job; buffer_full  in  1  sink backpressure.
REQ-008 result  out  NUM_WORDS*WORD_W  capture register; busy  out  1  job active; done  out  1  one-cycle job-complete pulse; overflow  out  1  sticky beat-dropped flag.

Function
REQ-009 Each accepted beat SHALL push R words into the FIFO, bus_data[WORD_W-1:0] first, ascending.
REQ-010 read_ready SHALL be high iff FIFO free words >= FIFO_DEPTH/2.
REQ-011 Beat arriving with free words < R SHALL be dropped entirely and set overflow; overflow clears only on reset or start.
REQ-012 Fetch FSM states: IDLE, REQ, WAIT_ACT, WAIT_DONE, FIN.
REQ-013 IDLE: start -> clear read_addr_index, latch num_bursts/mode, busy=1; -> REQ if num_bursts>0, else FIN.
REQ-014 REQ: waits for read_ready; then init_master_txn=1 for exactly one cycle, -> WAIT_ACT.
REQ-015 WAIT_ACT: read_active -> WAIT_DONE; WAIT_DONE: read_done -> read_addr_index+1, then REQ if new index < num_bursts, else FIN.
REQ-016 Expected word count SHALL be num_bursts*BEATS*R (computed at start, 16 bits min); drain counter counts popped words.
REQ-017 FIFO head SHALL be combinationally visible (show-ahead); pop and push in same cycle both SHALL take effect.
REQ-018 Stream mode: when FIFO non-empty and buffer_full=0, SHALL drive keccak_input=head, in_ready=1 and pop that cycle; in_ready=0 otherwise.
REQ-019 is_last SHALL be 1 only in the in_ready cycle of the word whose pop reaches the expected count.
REQ-020 Capture mode: each pop SHALL write result slot word_cnt mod NUM_WORDS ([WORD_W*k +: WORD_W]), one word per cycle, ignoring buffer_full; in_ready stays 0; slot index wraps to 0 after NUM_WORDS-1.
REQ-021 Words popped beyond the expected count SHALL NOT occur; surplus FIFO data SHALL be flushed at job end.
REQ-022 FIN: when drained count equals expected, done=1 for one cycle, busy=0, -> IDLE; num_bursts=0 gives done one cycle after start.
REQ-023 start while busy SHALL be ignored; result holds its value between jobs.

Reset
REQ-024 reset SHALL clear FIFO, counters, read_addr_index, init_master_txn, in_ready, is_last, done, busy, overflow to 0, fetch FSM to IDLE, and set result to all bytes 8'hC3.
REQ-025 reset asserted mid-job SHALL abort it with no done pulse; inputs other than reset are ignored in the reset cycle.

Verification
REQ-026 Capture, num_bursts=4, one beat per burst 128'h{i*2+1,i*2} -> 4 init pulses, index 0..3, result words 0..7 = 0..7, one done pulse.
REQ-027 Stream, num_bursts=2, buffer_full toggling every cycle -> 4 words in order, in_ready only when buffer_full=0, is_last on word 4 only.
REQ-028 num_bursts=0 -> no init_master_txn, done exactly one cycle after start, result unchanged (8'hC3 after reset).
REQ-029 Force 2 beats with FIFO holding FIFO_DEPTH-1 words -> beats dropped, overflow=1 until next start; read_ready=0 while free < FIFO_DEPTH/2.
REQ-030 Capture, num_bursts=6 -> slots wrap; result words 0..3 = words 8..11, 4..7 = words 4..7.
REQ-031 reset during WAIT_DONE -> all outputs at reset values next cycle, no done, new start runs normally.
